// File: rtl/uart_rx_param.sv
// UART receiver with configurable bit period, word width, parity and stop bits.
// The line is synchronized and each bit is sampled near its centre. Completed
// words sit in a valid/ready holding register. If a word completes while the
// previous one is still unread, the new word is dropped and overrun pulses.
module uart_rx_param #(
  parameter int unsigned CLKS_PER_BIT = 16'd100,
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned PARITY       = 0,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx_serial,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun
);

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StStart = 3'd1;
  localparam logic [2:0] StData  = 3'd2;
  localparam logic [2:0] StPar   = 3'd3;
  localparam logic [2:0] StStop  = 3'd4;

  localparam logic [15:0] BitMax   = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] HalfMax  = 16'((CLKS_PER_BIT / 2) - 1);
  localparam logic [3:0]  LastData = 4'(DATA_BITS - 1);
  localparam logic [3:0]  LastStop = 4'(STOP_BITS - 1);

  logic                 r_sync1, r_sync2, r_prev;
  logic [2:0]           r_state, w_state_d;
  logic [15:0]          r_clk_cnt, w_clk_cnt_d;
  logic [3:0]           r_bit_cnt, w_bit_cnt_d;
  logic [DATA_BITS-1:0] r_shift, w_shift_d;
  logic                 r_par_bit, w_par_bit_d;
  logic                 r_ferr_acc, w_ferr_acc_d;
  logic                 r_done, w_done_d;
  logic [DATA_BITS-1:0] r_data;
  logic                 r_valid, r_perr, r_ferr, r_overrun;
  logic                 w_par_xor, w_perr_new;

  // Two-flop synchronizer plus the previous synchronized level for edge detect.
  // r_prev only reads 1 once the line has really been high, which holds off
  // a restart after a break until the line returns to idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_prev  <= 1'b1;
    end else begin
      r_sync1 <= rx_serial;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  end

  // Receive FSM next-state: bit timing, sampling and frame assembly.
  always_comb begin
    w_state_d    = r_state;
    w_clk_cnt_d  = r_clk_cnt + 16'd1;
    w_bit_cnt_d  = r_bit_cnt;
    w_shift_d    = r_shift;
    w_par_bit_d  = r_par_bit;
    w_ferr_acc_d = r_ferr_acc;
    w_done_d     = 1'b0;
    case (r_state)
      StIdle: begin
        w_clk_cnt_d = 16'd0;
        if (r_prev && !r_sync2) begin
          w_state_d    = StStart;
          w_bit_cnt_d  = 4'd0;
          w_ferr_acc_d = 1'b0;
          w_par_bit_d  = 1'b0;
        end
      end
      StStart: begin
        if (r_clk_cnt == HalfMax) begin
          w_clk_cnt_d = 16'd0;
          // A high sample at mid-start is a glitch, not a frame.
          w_state_d   = r_sync2 ? StIdle : StData;
        end
      end
      StData: begin
        if (r_clk_cnt == BitMax) begin
          w_clk_cnt_d = 16'd0;
          w_shift_d   = {r_sync2, r_shift[DATA_BITS-1:1]};
          if (r_bit_cnt == LastData) begin
            w_bit_cnt_d = 4'd0;
            w_state_d   = (PARITY != 0) ? StPar : StStop;
          end else begin
            w_bit_cnt_d = r_bit_cnt + 4'd1;
          end
        end
      end
      StPar: begin
        if (r_clk_cnt == BitMax) begin
          w_clk_cnt_d = 16'd0;
          w_par_bit_d = r_sync2;
          w_state_d   = StStop;
        end
      end
      StStop: begin
        if (r_clk_cnt == BitMax) begin
          w_clk_cnt_d = 16'd0;
          if (!r_sync2) w_ferr_acc_d = 1'b1;
          if (r_bit_cnt == LastStop) begin
            w_bit_cnt_d = 4'd0;
            w_state_d   = StIdle;
            w_done_d    = 1'b1;
          end else begin
            w_bit_cnt_d = r_bit_cnt + 4'd1;
          end
        end
      end
      default: begin
        w_state_d   = StIdle;
        w_clk_cnt_d = 16'd0;
      end
    endcase
  end

  // Receive FSM state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= StIdle;
      r_clk_cnt  <= 16'd0;
      r_bit_cnt  <= 4'd0;
      r_shift    <= '0;
      r_par_bit  <= 1'b0;
      r_ferr_acc <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state_d;
      r_clk_cnt  <= w_clk_cnt_d;
      r_bit_cnt  <= w_bit_cnt_d;
      r_shift    <= w_shift_d;
      r_par_bit  <= w_par_bit_d;
      r_ferr_acc <= w_ferr_acc_d;
      r_done     <= w_done_d;
    end
  end

  // Odd parity wants the total XOR at 1, even wants it at 0.
  always_comb begin
    w_par_xor = (^r_shift) ^ r_par_bit;
    if (PARITY == 1)      w_perr_new = ~w_par_xor;
    else if (PARITY == 2) w_perr_new = w_par_xor;
    else                  w_perr_new = 1'b0;
  end

  // Output holding register with valid/ready handshake and overrun detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data    <= '0;
      r_valid   <= 1'b0;
      r_perr    <= 1'b0;
      r_ferr    <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_overrun <= 1'b0;
      if (r_done && (!r_valid || rx_ready)) begin
        r_data  <= r_shift;
        r_perr  <= w_perr_new;
        r_ferr  <= r_ferr_acc;
        r_valid <= 1'b1;
      end else if (r_done) begin
        r_overrun <= 1'b1;
      end else if (r_valid && rx_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign rx_data    = r_data;
  assign rx_valid   = r_valid;
  assign parity_err = r_perr;
  assign frame_err  = r_ferr;
  assign overrun    = r_overrun;

endmodule

// File: doc/uart_rx_param.md
UART_RX_PARAM -- requirements
Module: uart_rx_param

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 Parameter CLKS_PER_BIT, default 16'd100, SHALL set clock cycles per serial bit; legal range is 4..65535.
REQ-003 Parameter DATA_BITS, default 8, SHALL set data bits per frame; legal range is 5..9.
REQ-004 Parameter PARITY, default 0, SHALL select the parity mode: 0 = none, 1 = odd, 2 = even.
REQ-005 Parameter STOP_BITS, default 1, SHALL set stop bits per frame; legal values are 1 and 2.
REQ-006 clk  in  1  system clock; all state SHALL be on the rising edge.
REQ-007 rst_n  in  1  asynchronous active-low reset.
REQ-008 rx_serial  in  1  asynchronous serial line; it idles high.
REQ-009 rx_data  out  DATA_BITS  received word, LSB first on the line.
REQ-010 rx_valid  out  1  rx_data and the error flags hold a word.
REQ-011 rx_ready  in  1  consumer accepts the word.
REQ-012 parity_err  out  1  parity mismatch for the held word; SHALL be 0 when PARITY=0.
REQ-013 frame_err  out  1  a stop bit was sampled low for the held word.
REQ-014 overrun  out  1  one-cycle pulse when a completed frame is dropped.

Function
REQ-015 rx_serial SHALL pass through a 2-flop synchronizer, reset to 1, before any use.
REQ-016 The FSM SHALL have the states IDLE, START, DATA, PAR, STOP.
REQ-017 In IDLE, a synchronized 1-to-0 transition SHALL move the FSM to START and clear the bit counter.
REQ-018 START SHALL wait floor(CLKS_PER_BIT/2) cycles, then sample the line.
- Sample low: go to DATA.
- Sample high: false start; return to IDLE with no output change.
REQ-019 DATA SHALL sample DATA_BITS bits, each CLKS_PER_BIT cycles after the previous sample, into a shift register, LSB first.
REQ-020 After the last data bit, the FSM SHALL go to PAR when PARITY!=0; otherwise it SHALL go to STOP.
REQ-021 PAR SHALL sample one bit CLKS_PER_BIT cycles later and check it.
- Odd mode: the XOR of the data bits and the parity bit must be 1.
- Even mode: that XOR must be 0.
REQ-022 STOP SHALL sample STOP_BITS bits at CLKS_PER_BIT spacing; any low sample SHALL set the frame error.
REQ-023 After the last stop sample, the FSM SHALL return to IDLE in the next cycle, so a start edge is detectable immediately.
REQ-024 Frame completion occurs on the cycle after the last stop sample.
- If rx_valid=0, or rx_valid=1 and rx_ready=1 in that cycle, the block SHALL load rx_data, parity_err and frame_err and set rx_valid=1.
REQ-025 If rx_valid=1 and rx_ready=0 at completion, the new frame SHALL be discarded and overrun SHALL pulse for exactly one cycle; held outputs SHALL remain unchanged.
REQ-026 rx_valid SHALL clear on the cycle after rx_valid and rx_ready are both 1, unless a new load coincides (REQ-024).
REQ-027 rx_data and the flags SHALL be stable while rx_valid=1 and rx_ready=0.
REQ-028 Frames with errors SHALL still be delivered, with their flags set.
REQ-029 A break (line held low) SHALL produce one frame with frame_err=1.
- No further frame SHALL start until the line has been sampled high in IDLE.
REQ-030 The bit-period counter SHALL be 16 bits and SHALL reload at each sample; the bit counter SHALL wrap to 0 on each new frame.
REQ-031 Latency from the line edge at the centre of the last stop bit to rx_valid SHALL be 2 synchronizer cycles plus 1 load cycle, with ±1 cycle edge-detect jitter.

Reset
REQ-032 While rst_n=0, the block SHALL hold: FSM=IDLE, synchronizer=1, counters=0, rx_data=0, rx_valid=0, parity_err=0, frame_err=0, overrun=0.
REQ-033 Reset asserted mid-frame SHALL abort the frame with no output.
- After release, the first clean frame SHALL be received correctly.

Verification (clk 10 ns, CLKS_PER_BIT=100)
REQ-034 Defaults, byte 0xA5, rx_ready=1 -> one rx_valid pulse, rx_data=0xA5, both error flags 0.
REQ-035 PARITY=2, data 0x3C sent with parity bit 1 -> rx_data=0x3C, parity_err=1; with parity bit 0 -> parity_err=0.
REQ-036 Byte 0x55 with stop bit 0 -> rx_data=0x55, frame_err=1; the next clean frame 0x0F -> frame_err=0.
REQ-037 A 30-cycle low glitch on an idle line -> no rx_valid, FSM back in IDLE, and a following frame 0x81 is received correctly.
REQ-038 rx_ready=0, frames 0x11 then 0x22 back-to-back -> rx_data stays 0x11, one overrun pulse; after rx_ready=1, rx_valid clears.
REQ-039 rst_n pulsed low during data bit 3 of 0x7E, then frame 0xC3 -> no output for 0x7E, rx_data=0xC3 delivered; DATA_BITS=9, STOP_BITS=2, word 0x1AB -> rx_data=0x1AB.
